// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. Covers the hazards
// that forwarding cannot resolve: load-use, branch/JALR operands still
// arriving from a load in MEM, multi-cycle mul/div occupancy of EX, and
// data-memory wait states. Outputs are combinational from the current state
// and the inputs; state and counters update on the rising clock edge.
module hazard_stall_controller #(
    parameter int REGFILE_LEN    = 6,
    parameter int INSTR_WIDTH    = 32,
    parameter int OPCODE_WIDTH   = 7,
    parameter int CNT_WIDTH      = 32,
    parameter int MULDIV_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instr_IF_ID,
    input  logic [REGFILE_LEN-1:0] rs1_IF_ID,
    input  logic [REGFILE_LEN-1:0] rs2_IF_ID,
    input  logic [REGFILE_LEN-1:0] rd_ID_EX,
    input  logic                   reg_write_ID_EX,
    input  logic                   mem_read_ID_EX,
    input  logic [REGFILE_LEN-1:0] rd_EX_MEM,
    input  logic                   mem_read_EX_MEM,
    input  logic                   muldiv_start,
    input  logic                   muldiv_done,
    input  logic                   dmem_wait,
    input  logic                   redirect_req,
    output logic                   stall_PC,
    output logic                   stall_IF_ID,
    output logic                   stall_ID_EX,
    output logic                   stall_EX_MEM,
    output logic                   bubble_ID_EX,
    output logic                   bubble_EX_MEM,
    output logic                   bubble_MEM_WB,
    output logic                   flush_IF_ID,
    output logic                   redirect_ack,
    output logic [1:0]             ctrl_state,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    // Controller states
    localparam logic [1:0] ST_RUN         = 2'b00;
    localparam logic [1:0] ST_MULDIV_WAIT = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT    = 2'b10;

    // Timeout counter wide enough to hold MULDIV_TIMEOUT-1
    localparam int TO_WIDTH = $clog2(MULDIV_TIMEOUT) + 1;
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MULDIV_TIMEOUT - 1);

    // RISC-V major opcodes relevant to source-register usage
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP     = OPCODE_WIDTH'(7'b0110011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE  = OPCODE_WIDTH'(7'b0100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [OPCODE_WIDTH-1:0] OPC_JALR   = OPCODE_WIDTH'(7'b1100111);

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [TO_WIDTH-1:0]  to_cnt_reg;
    logic [TO_WIDTH-1:0]  to_cnt_next;
    logic [CNT_WIDTH-1:0] stall_cycles_reg;

    // Only the opcode field matters here; rd write-enable is implied by
    // mem_read for the loads this block cares about.
    logic unused_sigs;
    assign unused_sigs = ^{reg_write_ID_EX, instr_IF_ID[INSTR_WIDTH-1:OPCODE_WIDTH]};

    // ------------------------------------------------------------------
    // Opcode decode of the instruction sitting in ID
    // ------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0] opcode;
    logic is_r, is_ialu, is_load, is_store, is_branch, is_jalr;
    logic is_ctrl;

    assign opcode    = instr_IF_ID[OPCODE_WIDTH-1:0];
    assign is_r      = (opcode == OPC_OP);
    assign is_ialu   = (opcode == OPC_OP_IMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_ctrl   = is_branch | is_jalr;

    // Per-source view: index and whether the opcode actually reads it
    logic [REGFILE_LEN-1:0] src_idx  [2];
    logic                   src_used [2];

    assign src_idx[0]  = rs1_IF_ID;
    assign src_idx[1]  = rs2_IF_ID;
    assign src_used[0] = is_r | is_ialu | is_load | is_store | is_branch | is_jalr;
    assign src_used[1] = is_r | is_store | is_branch;

    // Match each used, nonzero source against the EX and MEM destinations.
    // x0 never creates a dependency.
    logic [1:0] ex_match;
    logic [1:0] mem_match;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign ex_match[gi]  = src_used[gi] && (src_idx[gi] != '0) &&
                                   (src_idx[gi] == rd_ID_EX);
            assign mem_match[gi] = src_used[gi] && (src_idx[gi] != '0) &&
                                   (src_idx[gi] == rd_EX_MEM);
        end
    endgenerate

    logic load_use;
    logic br_load_mem;
    logic muldiv_multi;

    // Load in EX feeding any used source of the ID instruction
    assign load_use    = mem_read_ID_EX && (rd_ID_EX != '0) && (|ex_match);
    // Branch/JALR resolves in ID, so a load still in MEM is too late to forward
    assign br_load_mem = is_ctrl && mem_read_EX_MEM && (rd_EX_MEM != '0) && (|mem_match);
    // A start that completes in the same cycle behaves as a single-cycle op
    assign muldiv_multi = muldiv_start && !muldiv_done;

    // ------------------------------------------------------------------
    // Next-state and raw output decode
    // ------------------------------------------------------------------
    logic stall_pc_raw, stall_if_id_raw, stall_id_ex_raw, stall_ex_mem_raw;
    logic bubble_id_ex_raw, bubble_ex_mem_raw, bubble_mem_wb_raw;
    logic flush_if_id_raw, redirect_ack_raw;

    // Priority-ordered stall/flush selection per state
    always_comb begin
        state_next        = state_reg;
        to_cnt_next       = to_cnt_reg;
        stall_pc_raw      = 1'b0;
        stall_if_id_raw   = 1'b0;
        stall_id_ex_raw   = 1'b0;
        stall_ex_mem_raw  = 1'b0;
        bubble_id_ex_raw  = 1'b0;
        bubble_ex_mem_raw = 1'b0;
        bubble_mem_wb_raw = 1'b0;
        flush_if_id_raw   = 1'b0;
        redirect_ack_raw  = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (dmem_wait) begin
                    // Freeze everything up to MEM, drain nothing into WB
                    stall_pc_raw      = 1'b1;
                    stall_if_id_raw   = 1'b1;
                    stall_id_ex_raw   = 1'b1;
                    stall_ex_mem_raw  = 1'b1;
                    bubble_mem_wb_raw = 1'b1;
                    state_next        = ST_MEM_WAIT;
                end else if (muldiv_multi) begin
                    // EX is occupied: hold the front end, feed NOPs to MEM
                    stall_pc_raw      = 1'b1;
                    stall_if_id_raw   = 1'b1;
                    stall_id_ex_raw   = 1'b1;
                    bubble_ex_mem_raw = 1'b1;
                    state_next        = ST_MULDIV_WAIT;
                    to_cnt_next       = '0;
                end else if (load_use || br_load_mem) begin
                    // Hold the consumer in ID and insert one bubble into EX
                    stall_pc_raw      = 1'b1;
                    stall_if_id_raw   = 1'b1;
                    bubble_id_ex_raw  = 1'b1;
                end else if (redirect_req) begin
                    // Operands are current, so the redirect may proceed
                    redirect_ack_raw  = 1'b1;
                    flush_if_id_raw   = 1'b1;
                end
            end

            ST_MULDIV_WAIT: begin
                stall_pc_raw      = 1'b1;
                stall_if_id_raw   = 1'b1;
                stall_id_ex_raw   = 1'b1;
                bubble_ex_mem_raw = 1'b1;
                to_cnt_next       = to_cnt_reg + TO_WIDTH'(1);
                if (dmem_wait) begin
                    // Memory stall overrides; the muldiv hold is not resumed
                    stall_ex_mem_raw  = 1'b1;
                    bubble_mem_wb_raw = 1'b1;
                    state_next        = ST_MEM_WAIT;
                end else if (muldiv_done || (to_cnt_reg == TO_LAST)) begin
                    // Exit cycle is still stalled; release next cycle
                    state_next        = ST_RUN;
                end
            end

            ST_MEM_WAIT: begin
                if (dmem_wait) begin
                    stall_pc_raw      = 1'b1;
                    stall_if_id_raw   = 1'b1;
                    stall_id_ex_raw   = 1'b1;
                    stall_ex_mem_raw  = 1'b1;
                    bubble_mem_wb_raw = 1'b1;
                end else begin
                    state_next        = ST_RUN;
                end
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // While reset is held every control output is forced low, even though
    // the inputs might otherwise request a stall in RUN.
    assign stall_PC      = stall_pc_raw      & ~rst;
    assign stall_IF_ID   = stall_if_id_raw   & ~rst;
    assign stall_ID_EX   = stall_id_ex_raw   & ~rst;
    assign stall_EX_MEM  = stall_ex_mem_raw  & ~rst;
    assign bubble_ID_EX  = bubble_id_ex_raw  & ~rst;
    assign bubble_EX_MEM = bubble_ex_mem_raw & ~rst;
    assign bubble_MEM_WB = bubble_mem_wb_raw & ~rst;
    assign flush_IF_ID   = flush_if_id_raw   & ~rst;
    assign redirect_ack  = redirect_ack_raw  & ~rst;
    assign ctrl_state    = state_reg;
    assign stall_cycles  = stall_cycles_reg;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // State register and muldiv timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            to_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (stall_PC && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Sits beside the forwarding unit in core/pipeline/hazard.
- Covers the hazards forwarding cannot: load-use, branch/JALR operands still in flight from a load, multi-cycle mul/div occupancy of EX, and data-memory wait.
- Drives per-stage hold/bubble/flush enables and a saturating stall-cycle counter.

Parameters:
- REGFILE_LEN, 6, register index width.
- INSTR_WIDTH, 32, instruction width.
- OPCODE_WIDTH, 7, opcode field width.
- CNT_WIDTH, 32, stall counter width.
- MULDIV_TIMEOUT, 64, max cycles in MULDIV_WAIT before forced exit.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- instr_IF_ID  in  INSTR_WIDTH  instruction in ID
- rs1_IF_ID  in  REGFILE_LEN  ID source 1
- rs2_IF_ID  in  REGFILE_LEN  ID source 2
- rd_ID_EX  in  REGFILE_LEN  EX destination
- reg_write_ID_EX  in  1  EX writes a register
- mem_read_ID_EX  in  1  EX is a load
- rd_EX_MEM  in  REGFILE_LEN  MEM destination
- mem_read_EX_MEM  in  1  MEM is a load
- muldiv_start  in  1  pulse: multi-cycle op entered EX
- muldiv_done  in  1  pulse: result valid
- dmem_wait  in  1  data memory not ready this cycle
- redirect_req  in  1  branch taken / JALR resolved in ID
- stall_PC  out  1  hold PC
- stall_IF_ID  out  1  hold IF/ID
- stall_ID_EX  out  1  hold ID/EX
- stall_EX_MEM  out  1  hold EX/MEM
- bubble_ID_EX  out  1  load NOP into ID/EX
- bubble_EX_MEM  out  1  load NOP into EX/MEM
- bubble_MEM_WB  out  1  load NOP into MEM/WB
- flush_IF_ID  out  1  squash IF/ID
- redirect_ack  out  1  PC may take redirect target
- ctrl_state  out  2  00 RUN, 01 MULDIV_WAIT, 10 MEM_WAIT
- stall_cycles  out  CNT_WIDTH  saturating count of cycles with stall_PC=1

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high. On rst: state RUN, timeout counter 0, stall_cycles 0, all 1-bit outputs 0.
- Outputs are combinational from state plus inputs; state and counters update on posedge clk.
- Source usage is decoded from the opcode in instr_IF_ID.
  - rs1 is used by R, I-ALU, load, store, branch, and JALR.
  - rs2 is used by R, store, and branch.
  - A match on x0 is never a hazard.
- Hazard terms, evaluated in RUN only:
  - load_use: mem_read_ID_EX, rd_ID_EX nonzero, and rd_ID_EX equal to a used source.
  - br_load_mem: ID holds a branch or JALR, mem_read_EX_MEM, rd_EX_MEM nonzero, and rd_EX_MEM matches a used source.
  - Branch on a load two ahead therefore stalls 2 cycles: load_use, then br_load_mem.
  - ALU results reach branches through forwarding; no stall.
- RUN, highest priority first:
  - dmem_wait: stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM and bubble_MEM_WB asserted; next state MEM_WAIT.
  - muldiv_start: stall_PC, stall_IF_ID, stall_ID_EX and bubble_EX_MEM asserted; next state MULDIV_WAIT; timeout counter cleared.
  - load_use or br_load_mem: stall_PC, stall_IF_ID and bubble_ID_EX asserted; stay RUN.
  - redirect_req with no stall active: redirect_ack=1 and flush_IF_ID=1. redirect_req during any stall is ignored (redirect_ack=0), since operands are stale.
- MEM_WAIT:
  - While dmem_wait=1: same outputs as RUN/dmem_wait.
  - When dmem_wait=0: outputs deasserted this cycle; next state RUN.
- MULDIV_WAIT:
  - Holds PC, IF_ID and ID_EX; bubbles EX_MEM; timeout counter increments.
  - Exit to RUN when muldiv_done=1, or when the count reaches MULDIV_TIMEOUT-1. The exit cycle is still stalled.
  - dmem_wait in this state adds stall_EX_MEM and bubble_MEM_WB, then moves to MEM_WAIT. The muldiv hold is then not resumed; done is required to arrive before memory completes.
- muldiv_start and muldiv_done in the same RUN cycle: treated as a single-cycle op, no state change.
- stall_cycles increments on every cycle with stall_PC=1 and saturates at all-ones.
- Async rst mid-stall returns to RUN immediately; outputs drop in the same cycle.

Test Plan:
- lw x5 in EX (mem_read_ID_EX=1, rd_ID_EX=5); add x6,x5,x1 in ID -> one cycle of stall_PC=stall_IF_ID=bubble_ID_EX=1; next cycle all 0; stall_cycles=1.
- lw x5 in EX; beq x5,x0 in ID -> cycle 1 via load_use, cycle 2 via br_load_mem (rd_EX_MEM=5); 2 stall cycles; redirect_req ignored in both, redirect_ack only in cycle 3.
- rd_ID_EX=0 with mem_read_ID_EX=1; add x6,x0,x0 in ID -> no stall.
- muldiv_start, then muldiv_done 5 cycles later -> ctrl_state=01 for 5 cycles; stall_ID_EX and bubble_EX_MEM high through the done cycle; back to 00.
- muldiv_start with no done -> exit after 64 cycles; stall_cycles=65.
- dmem_wait for 3 cycles with rst pulsed on cycle 2 -> outputs 0 and state RUN immediately at rst; stall_cycles=0.
